// File: rtl/axi_store_responder_pkg.sv
// Shared types for the AXI store responder.
// Response encodings and control FSM states.
package axi_store_responder_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DRAIN,
    RESP
  } state_e;

  localparam int unsigned LenWidth = 8;

endpackage

// File: rtl/axi_store_responder_resp_fifo.sv
// Generic synchronous FIFO with first-word fall-through output.
// Allows push on full when a pop happens in the same cycle.
module resp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (r_cnt == CntW'(Depth));
  assign empty_o = (r_cnt == '0);
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop)  r_rptr <= f_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/axi_store_responder.sv
// Single-beat AXI write responder backed by a small word memory.
// Bursts are drained and answered SLVERR; out-of-range gets DECERR.
module axi_store_responder
  import axi_store_responder_pkg::*;
#(
  parameter int unsigned          IdWidth        = 4,
  parameter int unsigned          AddrWidth      = 64,
  parameter int unsigned          DataWidth      = 64,
  parameter int unsigned          MaxOutstanding = 7,
  parameter int unsigned          NumWords       = 16,
  parameter logic [AddrWidth-1:0] BaseAddr       = 64'h8000_0000
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              aw_valid_i,
  output logic                              aw_ready_o,
  input  logic [IdWidth-1:0]                aw_id_i,
  input  logic [AddrWidth-1:0]              aw_addr_i,
  input  logic [LenWidth-1:0]               aw_len_i,
  input  logic                              w_valid_i,
  output logic                              w_ready_o,
  input  logic [DataWidth-1:0]              w_data_i,
  input  logic [DataWidth/8-1:0]            w_strb_i,
  input  logic                              w_last_i,
  output logic                              b_valid_o,
  input  logic                              b_ready_i,
  output logic [IdWidth-1:0]                b_id_o,
  output logic [1:0]                        b_resp_o,
  input  logic [$clog2(NumWords)-1:0]       rd_idx_i,
  output logic [DataWidth-1:0]              rd_data_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);

  localparam int unsigned Bytes = DataWidth / 8;
  localparam int unsigned OffW  = $clog2(Bytes);
  localparam int unsigned IdxW  = $clog2(NumWords);
  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned AwW   = IdWidth + 2 + IdxW;
  localparam int unsigned BW    = IdWidth + 2;
  localparam logic [AddrWidth-1:0] Span =
    AddrWidth'(NumWords * Bytes);

  state_e               r_state;
  state_e               w_next;
  resp_e                r_resp;
  resp_e                w_aw_resp;
  logic [DataWidth-1:0] r_mem [NumWords];
  logic [OutW-1:0]      r_out;

  logic [AddrWidth-1:0] w_off;
  logic                 w_inrange;
  logic [IdxW-1:0]      w_idx;
  logic                 w_aw_hs;
  logic                 w_b_hs;
  logic                 w_aw_full;
  logic                 w_aw_empty;
  logic [AwW-1:0]       w_aw_q;
  logic [IdWidth-1:0]   w_hd_id;
  logic [1:0]           w_hd_resp;
  logic [IdxW-1:0]      w_hd_idx;
  logic                 w_b_push;
  logic                 w_b_full;
  logic                 w_b_empty;
  logic [BW-1:0]        w_b_q;
  logic                 w_mem_we;

  // Classify at AW acceptance so the FIFO only holds id, class and index
  assign w_off     = aw_addr_i - BaseAddr;
  assign w_inrange = (aw_addr_i >= BaseAddr) && (w_off < Span);
  assign w_idx     = IdxW'(w_off >> OffW);

  always_comb begin
    w_aw_resp = OKAY;
    if (!w_inrange)            w_aw_resp = DECERR;
    else if (aw_len_i != '0)   w_aw_resp = SLVERR;
  end

  assign aw_ready_o = rst_ni && !w_aw_full &&
                      (r_out < OutW'(MaxOutstanding));
  assign w_aw_hs    = aw_valid_i && aw_ready_o;
  assign w_b_hs     = b_valid_o && b_ready_i;

  resp_fifo #(.Width(AwW), .Depth(MaxOutstanding)) u_aw_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_aw_hs),
    .data_i  ({aw_id_i, w_aw_resp, w_idx}),
    .pop_i   (w_b_push),
    .data_o  (w_aw_q),
    .full_o  (w_aw_full),
    .empty_o (w_aw_empty)
  );

  assign {w_hd_id, w_hd_resp, w_hd_idx} = w_aw_q;

  resp_fifo #(.Width(BW), .Depth(MaxOutstanding)) u_b_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_b_push),
    .data_i  ({w_hd_id, r_resp}),
    .pop_i   (w_b_hs),
    .data_o  (w_b_q),
    .full_o  (w_b_full),
    .empty_o (w_b_empty)
  );

  assign b_valid_o = !w_b_empty;
  assign b_id_o    = w_b_empty ? '0 : w_b_q[BW-1:2];
  assign b_resp_o  = w_b_empty ? '0 : w_b_q[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (!w_aw_empty) w_next = WRITE;
      WRITE: if (w_valid_i)   w_next = w_last_i ? RESP : DRAIN;
      DRAIN: if (w_valid_i && w_last_i) w_next = RESP;
      RESP:  if (w_b_push)    w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ready_o = 1'b0;
    w_b_push  = 1'b0;
    w_mem_we  = 1'b0;
    unique case (r_state)
      WRITE: begin
        w_ready_o = 1'b1;
        w_mem_we  = w_valid_i && (w_hd_resp == OKAY);
      end
      DRAIN: w_ready_o = 1'b1;
      RESP:  w_b_push  = !w_b_full || w_b_hs;
      default: ;
    endcase
  end

  // A single-beat AW that sees a non-last first beat degrades to SLVERR
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resp <= OKAY;
    end else if (r_state == WRITE && w_valid_i) begin
      if (w_hd_resp == OKAY && !w_last_i) r_resp <= SLVERR;
      else                                r_resp <= resp_e'(w_hd_resp);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out <= '0;
    end else begin
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_out <= r_out + OutW'(1);
        2'b01:   r_out <= r_out - OutW'(1);
        default: r_out <= r_out;
      endcase
    end
  end

  assign outstanding_o = r_out;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem <= '{default: '0};
    end else if (w_mem_we) begin
      for (int b = 0; b < Bytes; b++) begin
        if (w_strb_i[b]) r_mem[w_hd_idx][b*8 +: 8] <= w_data_i[b*8 +: 8];
      end
    end
  end

  assign rd_data_o = r_mem[rd_idx_i];

endmodule

// File: tb/tb_axi_store_responder.sv
// Directed bench for axi_store_responder.
// Expected B responses queue up at AW issue; a monitor checks them.
module tb_axi_store_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [1:0]  R_OK = 2'b00;
  localparam logic [1:0]  R_SE = 2'b10;
  localparam logic [1:0]  R_DE = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_valid, aw_ready;
  logic [3:0]  aw_id;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic [3:0]  rd_idx;
  logic [63:0] rd_data;
  logic [2:0]  outstanding;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          w_hs    = 0;
  logic [5:0]  exp_q[$];
  logic [63:0] model [16];

  always #5 clk = ~clk;

  axi_store_responder #(
    .IdWidth(4), .AddrWidth(64), .DataWidth(64),
    .MaxOutstanding(7), .NumWords(16), .BaseAddr(BASE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len),
    .w_valid_i(w_valid), .w_ready_o(w_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready),
    .b_id_o(b_id), .b_resp_o(b_resp),
    .rd_idx_i(rd_idx), .rd_data_o(rd_data),
    .outstanding_o(outstanding)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (w_valid && w_ready) w_hs++;
      if (b_valid && b_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL b_unexpected: got id %0d resp %0d expected none",
                   b_id, b_resp);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          chk("b_id", 64'(b_id), 64'(e[5:2]));
          chk("b_resp", 64'(b_resp), 64'(e[1:0]));
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [63:0] addr,
                       input logic [7:0] len, input logic [1:0] resp,
                       input bit expect_b);
    bit done;
    done = 0;
    sync();
    aw_valid = 1'b1;
    aw_id    = id;
    aw_addr  = addr;
    aw_len   = len;
    if (expect_b) exp_q.push_back({id, resp});
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (aw_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    aw_valid = 1'b0;
    if (!done) chk("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_w(input logic [63:0] data, input logic [7:0] strb,
                      input logic last);
    bit done;
    done = 0;
    sync();
    w_valid = 1'b1;
    w_data  = data;
    w_strb  = strb;
    w_last  = last;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (w_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    w_valid = 1'b0;
    if (!done) chk("w_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(negedge clk);
    chk("b_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_mem();
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      chk($sformatf("mem[%0d]", i), rd_data, model[i]);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_aw_ready", 64'(aw_ready), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_b_id", 64'(b_id), 64'd0);
    chk("rst_b_resp", 64'(b_resp), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
  endtask

  initial begin
    int hs0;
    rst_n = 1'b0;
    aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0;
    b_ready = 1'b1;
    rd_idx = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    #1;
    chk_reset_outs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("aw_ready_after_rst", 64'(aw_ready), 64'd1);

    // single write plus latency from the W handshake to b_valid
    do_aw(4'd3, BASE + 64'd8, 8'd0, R_OK, 1);
    do_w(64'hDEAD_BEEF, 8'hFF, 1'b1);
    @(negedge clk);
    chk("lat_cycle1_b_valid", 64'(b_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2_b_valid", 64'(b_valid), 64'd1);
    model[1] = 64'hDEAD_BEEF;
    wait_drain();
    rd_idx = 4'd1;
    #1;
    chk("single_write_word1", rd_data, 64'hDEAD_BEEF);

    do_aw(4'd1, BASE, 8'd0, R_OK, 1);
    do_w(64'h1111_2222_3333_4444, 8'h0F, 1'b1);
    model[0] = 64'h0000_0000_3333_4444;
    wait_drain();
    rd_idx = 4'd0;
    #1;
    chk("partial_strb_word0", rd_data, 64'h0000_0000_3333_4444);

    // W presented before its AW is held off until the AW arrives
    fork
      do_w(64'hCAFE_F00D_1234_5678, 8'hF0, 1'b1);
      begin
        sync();
        repeat (3) begin
          @(negedge clk);
          chk("w_held_before_aw", 64'(w_ready), 64'd0);
        end
        do_aw(4'd2, BASE + 64'd120, 8'd0, R_OK, 1);
      end
    join
    model[15] = 64'hCAFE_F00D_0000_0000;
    wait_drain();

    do_aw(4'd4, BASE + 64'd128, 8'd0, R_DE, 1);
    do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    do_aw(4'd7, BASE - 64'd8, 8'd0, R_DE, 1);
    do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    do_aw(4'd8, BASE + 64'd128, 8'd3, R_DE, 1);
    for (int i = 0; i < 4; i++) do_w(64'hFFFF, 8'hFF, i == 3);

    hs0 = w_hs;
    do_aw(4'd5, BASE, 8'd3, R_SE, 1);
    for (int i = 0; i < 4; i++) do_w(64'hABCD_0000 + 64'(i), 8'hFF, i == 3);
    wait_drain();
    chk("burst_w_handshakes", 64'(w_hs - hs0), 64'd4);

    do_aw(4'd6, BASE + 64'd8, 8'd1, R_SE, 1);
    do_w(64'h5555_5555, 8'hFF, 1'b1);
    wait_drain();
    chk_mem();

    // back-pressure: the B path is stalled while the AW slots fill
    b_ready = 1'b0;
    for (int i = 0; i < 7; i++)
      do_aw(4'(i + 9), BASE + 64'(8 * (2 + i)), 8'd0, R_OK, 1);
    sync();
    aw_valid = 1'b1;
    aw_id = 4'd0;
    aw_addr = BASE;
    aw_len = 8'd0;
    @(negedge clk);
    chk("aw_ready_8th", 64'(aw_ready), 64'd0);
    chk("outstanding_full", 64'(outstanding), 64'd7);
    @(posedge clk);
    #1;
    aw_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      do_w(64'h100 + 64'(i), 8'hFF, 1'b1);
      model[2 + i] = 64'h100 + 64'(i);
    end
    repeat (3) @(negedge clk);
    chk("outstanding_b_stalled", 64'(outstanding), 64'd7);
    chk("b_valid_stalled", 64'(b_valid), 64'd1);
    sync();
    b_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("outstanding_drained", 64'(outstanding), 64'd0);
    chk_mem();

    // reset in the middle of a drained burst abandons it
    do_aw(4'd5, BASE, 8'd2, R_SE, 0);
    do_w(64'h7777, 8'hFF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("aw_ready_after_rst2", 64'(aw_ready), 64'd1);
    for (int i = 0; i < 16; i++) model[i] = '0;
    chk_mem();
    do_aw(4'd6, BASE + 64'd24, 8'd0, R_OK, 1);
    do_w(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    model[3] = 64'h0123_4567_89AB_CDEF;
    wait_drain();
    repeat (4) @(negedge clk);
    chk("b_valid_idle", 64'(b_valid), 64'd0);
    chk("outstanding_end", 64'(outstanding), 64'd0);
    chk_mem();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_store_responder.md
AXI_STORE_RESPONDER -- requirements
Module: axi_store_responder

Interface
REQ-001 SHALL have parameter IdWidth, default 4, AXI ID width.
REQ-002 SHALL have parameter AddrWidth, default 64, AXI address width.
REQ-003 SHALL have parameter DataWidth, default 64, AXI data width (strobe width DataWidth/8).
REQ-004 SHALL have parameter MaxOutstanding, default 7, write transactions accepted but not yet answered on B.
REQ-005 SHALL have parameter NumWords, default 16, power of two, DataWidth-wide backing words.
REQ-006 SHALL have parameter BaseAddr, default 64'h8000_0000, first decoded byte address.
REQ-007 Ports, in this order:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- aw_valid_i / aw_ready_o, in / out, 1 each, AW handshake.
- aw_id_i, in, IdWidth, AW ID.
- aw_addr_i, in, AddrWidth, AW address.
- aw_len_i, in, 8, AW burst length.
- w_valid_i / w_ready_o, in / out, 1 each, W handshake.
- w_data_i, in, DataWidth, W data.
- w_strb_i, in, DataWidth/8, W byte strobes.
- w_last_i, in, 1, W last beat.
- b_valid_o / b_ready_i, out / in, 1 each, B handshake.
- b_id_o, out, IdWidth, B ID.
- b_resp_o, out, 2, B response.
- rd_idx_i, in, $clog2(NumWords), backdoor word index.
- rd_data_o, out, DataWidth, combinational backdoor read.
- outstanding_o, out, $clog2(MaxOutstanding+1), current outstanding count.

Function
REQ-008 AW SHALL go into an AW FIFO of depth MaxOutstanding; aw_ready_o = !full && outstanding < MaxOutstanding.
REQ-009 FSM states: IDLE, WRITE, DRAIN, RESP.
- IDLE -> WRITE when the AW FIFO is non-empty.
- WRITE: w_ready_o=1; the first W beat is handled this cycle. If w_last_i, go to RESP; otherwise go to DRAIN.
- DRAIN: w_ready_o=1; discard beats until w_last_i, then go to RESP.
- RESP: push {id, resp} into the B FIFO when it is not full, pop the AW FIFO, go to IDLE.
REQ-010 w_ready_o SHALL be 0 in IDLE and RESP.
REQ-011 Decode: in range iff BaseAddr <= addr < BaseAddr + NumWords*DataWidth/8; word index = (addr - BaseAddr) >> log2(DataWidth/8).
REQ-012 In range and aw_len_i == 0: write the first beat's bytes where strb=1, on the WRITE handshake; resp = OKAY (2'b00).
REQ-013 aw_len_i != 0: no memory update for any beat; resp = SLVERR (2'b10).
REQ-014 Out of range: no update; resp = DECERR (2'b11). This takes precedence over SLVERR.
REQ-015 If w_last_i does not match aw_len_i, the FSM SHALL still end on w_last_i, with SLVERR.
REQ-016 B FIFO depth MaxOutstanding; responses return in AW acceptance order (no ID reordering); b_valid_o = B FIFO non-empty.
REQ-017 Outstanding count: +1 on AW handshake, -1 on B handshake; same-cycle both = unchanged. It SHALL never exceed MaxOutstanding or wrap below 0.
REQ-018 Minimum latency, last W handshake to b_valid_o: 2 cycles (RESP push, then FIFO output registered).
REQ-019 A W beat arriving before its AW SHALL be held off (w_ready_o=0) and never lost.
REQ-020 Simultaneous push and pop on a full B FIFO SHALL be permitted; the RESP stall applies only when full with no pop.

Reset
REQ-021 rst_ni low SHALL asynchronously clear FSM to IDLE, empty both FIFOs, and zero the outstanding count.
REQ-022 Output values while rst_ni is low: aw_ready_o=0, w_ready_o=0, b_valid_o=0, b_id_o=0, b_resp_o=0, outstanding_o=0.
REQ-023 aw_ready_o SHALL assert the first cycle after reset release.
REQ-024 Backing memory SHALL reset to all-zero.
REQ-025 Reset mid-burst SHALL abandon the transaction with no B response and no further write.

Structure
REQ-026 Response encodings (OKAY/SLVERR/DECERR) and the FSM state enum SHALL live in a shared package, axi_store_responder_pkg.
REQ-027 One sub-module, a generic synchronous FIFO (resp_fifo), SHALL be instantiated twice: AW entries and B entries.

Verification
REQ-028 Single write: AW{id=3, addr=BaseAddr+8, len=0} + W{data=64'hDEAD_BEEF, strb=8'hFF, last=1} -> B{id=3, OKAY} 2 cycles after W; rd_data_o[1]=64'hDEAD_BEEF.
REQ-029 Partial strobe: strb=8'h0F, data=64'h1111_2222_3333_4444 over word 0 = 0 -> word 0 = 64'h0000_0000_3333_4444.
REQ-030 Back-pressure: hold b_ready_i=0 and issue 8 AWs -> 7 accepted, aw_ready_o=0 on the 8th, outstanding_o=7; release -> B IDs in issue order.
REQ-031 Errors:
- addr=BaseAddr+128 -> DECERR, memory unchanged.
- len=3 with 4 beats -> exactly 4 W handshakes, SLVERR, memory unchanged.
REQ-032 Reset asserted during DRAIN -> all outputs at reset values; next single write completes OKAY.
